bus_uart_tx: RTL and testbench
==============================

Name: bus_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the Core data bus as a responder, beside Memory.
- Uses the same signal set as Memory: memory_read, memory_write, address, write_data, read_data.
- Core stores bytes into a TX FIFO; a serializer drives 8N1 frames on uart_tx.
- The top level muxes read_data between Memory and this block using the hit output.

Parameters:
- BASE_ADDRESS, 32'h8000_0000, register window base; 16-byte window, decoded on address[31:4].
- CLK_FREQ, 25_000_000, clk frequency in Hz.
- BIT_RATE, 115200, reset baud rate.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of two, 2..256.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- memory_read  input  1  Core read strobe.
- memory_write  input  1  Core write strobe, one cycle per store.
- address  input  32  byte address; address[1:0] ignored.
- write_data  input  32  store data.
- read_data  output  32  load data.
- hit  output  1  address inside window (combinational).
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset: uart_tx=1, FIFO empty, FSM=IDLE, overflow=0, DIVIDER=CLK_FREQ/BIT_RATE-1 (truncated). read_data follows combinational rules.
- Register map (offset = address[3:2]):
  - 0 TXDATA: write pushes write_data[7:0]; reads as 0.
  - 1 STATUS, read: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO level, others 0. Writing 1 to bit 3 clears overflow.
  - 2 DIVIDER: R/W, 16 bits; upper bits write-ignored, read 0.
  - 3 CTRL: see Optional Feature; reads 0 without the feature.
- read_data: combinational. Equals the selected register when hit&&memory_read, else 32'h0. Zero-latency load, matching Memory.
- Write with memory_write=0 or hit=0 has no effect.
- Push to full FIFO:
  - If the serializer pops in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the byte is dropped and overflow is set.
- FSM states and transitions:
  - IDLE: uart_tx=1; if FIFO non-empty, pop into shift register, load baud counter with DIVIDER, go to START.
  - START: uart_tx=0 for DIVIDER+1 cycles, then DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first; each bit lasts DIVIDER+1 cycles; after bit 7 go to STOP.
  - STOP: uart_tx=1 for DIVIDER+1 cycles, then IDLE.
  - Back-to-back bytes: one IDLE cycle between frames, so a frame is 10*(DIVIDER+1)+1 cycles.
- Baud counter counts down to 0. A DIVIDER write mid-frame takes effect at the next bit reload and does not truncate the current bit.
- First bit timing: a push into an empty FIFO while IDLE makes START begin (uart_tx=0) two cycles after the write edge.
- Reset asserted mid-frame: uart_tx=1 and FIFO flushed on the next edge; no partial-frame completion.
- Simultaneous STATUS overflow-clear and a new overflow event: set wins.
- Level counter width: $clog2(FIFO_DEPTH)+1; STATUS[15:8] is zero-extended.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and CTRL bits: [0] empty_ie, [1] overflow_ie.
  - CTRL resets to 0.
  - irq = (empty_ie & empty & !busy) | (overflow_ie & overflow), registered, one-cycle delay.
- Not defined: no irq port; CTRL writes ignored, reads 0.

Decomposition:
- Package bus_uart_pkg holds:
  - register offset constants (TXDATA_OFF=2'd0, STATUS_OFF=2'd1, DIVIDER_OFF=2'd2, CTRL_OFF=2'd3);
  - STATUS/CTRL bit index constants;
  - FSM state typedef (IDLE, START, DATA, STOP).
- One sub-module: sync_fifo, parameterised width/depth, with push/pop/full/empty/level. It is reusable for a future bus_uart_rx.

Test Plan:
- Reset held low 3 cycles, then released, with no access: uart_tx=1, STATUS read = 32'h0000_0004, DIVIDER read = 216 (25 MHz/115200-1).
- Write DIVIDER=3, write TXDATA=8'hA5: start bit low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy=1 during the frame.
- Write 17 bytes 0x00..0x10 back-to-back with DIVIDER=3 and FIFO_DEPTH=16: first byte popped immediately, all 17 accepted, overflow=0. An 18th immediate write sets STATUS[3]=1; writing STATUS=32'h8 clears it.
- DIVIDER changed from 3 to 7 mid-DATA: current bit stays 4 cycles, subsequent bits 8 cycles.
- Pull reset low during bit 4 of frame 0x3C with 5 bytes queued: next edge gives uart_tx=1, level=0, STATUS=32'h4.
- With UART_TX_IRQ_EN, CTRL=1, one byte sent: irq rises 1 cycle after the FSM returns to IDLE with FIFO empty. Read of address outside the window returns 0 with hit=0.

Source files
------------

// File: rtl/bus_uart_pkg.sv
// rtl/bus_uart_pkg.sv - register map, bit positions and FSM states for the bus UART
package bus_uart_pkg;

  localparam logic [1:0] TXDATA_OFF  = 2'd0;
  localparam logic [1:0] STATUS_OFF  = 2'd1;
  localparam logic [1:0] DIVIDER_OFF = 2'd2;
  localparam logic [1:0] CTRL_OFF    = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_EMPTY_IE    = 0;
  localparam int CTRL_OVERFLOW_IE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level output; push into a full FIFO is
// accepted only when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 UART transmitter on the Core data bus;
// UART_TX_IRQ_EN adds the CTRL register and the irq output
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
  parameter int          CLK_FREQ     = 25_000_000,
  parameter int          BIT_RATE     = 115200,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        uart_tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int          LW            = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIVIDER_RESET = 16'(CLK_FREQ / BIT_RATE - 1);

  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          push_req;
  logic          fifo_pop;
  logic [7:0]    pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          overflow_set;
  logic [15:0]   divider;
  logic          busy;

  tx_state_e     state, state_next;
  logic [15:0]   baud_cnt, baud_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;

  logic          unused_bits;
  assign unused_bits = ^{address[1:0], write_data[31:16]};

  assign hit      = (address[31:4] == BASE_ADDRESS[31:4]);
  assign reg_sel  = address[3:2];
  assign wr_en    = hit && memory_write;
  assign push_req = wr_en && (reg_sel == TXDATA_OFF);
  assign busy     = (state != IDLE);

  // A push into a full FIFO is only lost when the serializer is not popping this cycle.
  assign overflow_set = push_req && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (write_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      divider  <= DIVIDER_RESET;
    end else begin
      if (overflow_set)
        overflow <= 1'b1;
      else if (wr_en && (reg_sel == STATUS_OFF) && write_data[ST_OVERFLOW])
        overflow <= 1'b0;
      if (wr_en && (reg_sel == DIVIDER_OFF))
        divider <= write_data[15:0];
    end
  end

`ifdef UART_TX_IRQ_EN
  logic [1:0] ctrl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == CTRL_OFF))
        ctrl <= write_data[1:0];
      irq <= (ctrl[CTRL_EMPTY_IE] && fifo_empty && !busy) ||
             (ctrl[CTRL_OVERFLOW_IE] && overflow);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      uart_tx  <= tx_next;
    end
  end

  // The divider is sampled only at bit reloads, so a mid-frame write never shortens a bit.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    fifo_pop      = 1'b0;
    tx_next       = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = pop_data;
          baud_cnt_next = divider;
          state_next    = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_cnt == '0) begin
          baud_cnt_next = divider;
          bit_idx_next  = 3'd0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_cnt == '0) begin
          baud_cnt_next = divider;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_cnt_next = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_cnt == '0)
          state_next = IDLE;
        else
          baud_cnt_next = baud_cnt - 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_data = 32'h0;
    if (hit && memory_read) begin
      case (reg_sel)
        STATUS_OFF: begin
          read_data[ST_BUSY]                     = busy;
          read_data[ST_FULL]                     = fifo_full;
          read_data[ST_EMPTY]                    = fifo_empty;
          read_data[ST_OVERFLOW]                 = overflow;
          read_data[ST_LEVEL_LSB+7:ST_LEVEL_LSB] = 8'(fifo_level);
        end
        DIVIDER_OFF: read_data[15:0] = divider;
`ifdef UART_TX_IRQ_EN
        CTRL_OFF:    read_data[1:0] = ctrl;
`endif
        default:     read_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb/tb_bus_uart_tx.sv - directed self-checking bench for bus_uart_tx
module tb_bus_uart_tx;

  localparam logic [31:0] A_TXDATA  = 32'h8000_0000;
  localparam logic [31:0] A_STATUS  = 32'h8000_0004;
  localparam logic [31:0] A_DIVIDER = 32'h8000_0008;
  localparam logic [31:0] A_CTRL    = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        hit;
  logic        uart_tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .memory_read  (memory_read),
    .memory_write (memory_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .hit          (hit),
    .uart_tx      (uart_tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address      = a;
    write_data   = d;
    memory_write = 1'b1;
    @(negedge clk);
    memory_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address     = a;
    memory_read = 1'b1;
    #1;
    d           = read_data;
    memory_read = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    int lows;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL %s actual=%0d low samples required=0", name, lows);
    end
  endtask

  task automatic rx_frames(input int n);
    logic [39:0] s;
    logic [7:0]  b;
    int          waited;
    for (int f = 0; f < n; f++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (uart_tx !== 1'b0 && waited < 200);
      if (uart_tx !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rx_start_timeout frame=%0d actual=no start required=start", f);
        break;
      end
      s = '0;
      for (int k = 1; k < 40; k++) begin
        @(negedge clk);
        s[k] = uart_tx;
      end
      for (int i = 0; i < 8; i++) b[i] = s[5 + 4 * i];
      checks++;
      if (b !== 8'(f) || s[37] !== 1'b1) begin
        errors++;
        $display("FAIL rx_byte frame=%0d actual=%h stop=%b required=%h stop=1", f, b, s[37], 8'(f));
      end
      if (f > 0) begin
        checks++;
        if (waited != 2) begin
          errors++;
          $display("FAIL rx_gap frame=%0d actual=%0d idle cycles required=1", f, waited - 1);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_uart_tx actual=%b required=1", uart_tx);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL reset_status actual=%h required=%h", d, 32'h4);
    end
    bus_read(A_DIVIDER, d);
    checks++;
    if (d !== 32'd216) begin
      errors++;
      $display("FAIL reset_divider actual=%0d required=216", d);
    end
    bus_read(A_TXDATA, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL txdata_reads_zero actual=%h required=0", d);
    end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_reset actual=%h required=0", d);
    end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    @(negedge clk);
    address     = 32'h8000_0010;
    memory_read = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0 || read_data !== 32'h0) begin
      errors++;
      $display("FAIL outside_window actual hit=%b data=%h required hit=0 data=0", hit, read_data);
    end
    address = 32'h7FFF_FFFC;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL below_window actual hit=%b required=0", hit);
    end
    memory_read = 1'b0;
    address     = A_STATUS;
    #1;
    checks++;
    if (hit !== 1'b1 || read_data !== 32'h0) begin
      errors++;
      $display("FAIL no_read_strobe actual hit=%b data=%h required hit=1 data=0", hit, read_data);
    end
    bus_write(32'h8000_0018, 32'h5);
    bus_read(32'h8000_000B, d);
    checks++;
    if (d !== 32'd216) begin
      errors++;
      $display("FAIL write_outside_ignored actual=%0d required=216", d);
    end
    bus_write(A_DIVIDER, 32'hABCD_0003);
    bus_read(A_DIVIDER, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL divider_upper_ignored actual=%h required=3", d);
    end
    bus_write(A_CTRL, 32'h3);
  endtask

  task automatic test_single_frame;
    logic [9:0]  frame;
    logic [39:0] obs;
    logic [39:0] exp_v;
    logic [39:0] busy_obs;
    logic [31:0] d;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) exp_v[k] = frame[k / 4];
    bus_write(A_TXDATA, 32'hFFFF_FFA5);
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL start_too_early actual=%b required=1", uart_tx);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs[k] = uart_tx;
      bus_read(A_STATUS, d);
      busy_obs[k] = d[0];
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL frame_a5 actual=%h required=%h", obs, exp_v);
    end
    checks++;
    if (busy_obs !== {1'b0, {39{1'b1}}}) begin
      errors++;
      $display("FAIL busy_during_frame actual=%h required=%h", busy_obs, {1'b0, {39{1'b1}}});
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL status_after_frame actual=%h required=4", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    fork
      begin
        @(negedge clk);
        address      = A_TXDATA;
        memory_write = 1'b1;
        for (int i = 0; i < 17; i++) begin
          write_data = i;
          @(negedge clk);
        end
        memory_write = 1'b0;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_1003) begin
          errors++;
          $display("FAIL status_full actual=%h required=%h", d, 32'h1003);
        end
        bus_write(A_TXDATA, 32'h11);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_100B) begin
          errors++;
          $display("FAIL overflow_set actual=%h required=%h", d, 32'h100B);
        end
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_1003) begin
          errors++;
          $display("FAIL overflow_clear actual=%h required=%h", d, 32'h1003);
        end
      end
      rx_frames(17);
    join
    check_quiet("dropped_byte_sent");
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL status_drained actual=%h required=4", d);
    end
  endtask

  task automatic test_divider_change;
    logic [7:0]  b;
    logic [67:0] obs;
    logic [67:0] exp_v;
    logic [31:0] d;
    int          waited;
    b = 8'h55;
    for (int k = 0; k < 68; k++) begin
      if (k < 4)       exp_v[k] = 1'b0;
      else if (k < 8)  exp_v[k] = b[0];
      else if (k < 12) exp_v[k] = b[1];
      else if (k < 60) exp_v[k] = b[2 + (k - 12) / 8];
      else             exp_v[k] = 1'b1;
    end
    bus_write(A_TXDATA, {24'h0, b});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (uart_tx !== 1'b0 && waited < 20);
    obs    = '0;
    obs[0] = uart_tx;
    for (int k = 1; k < 68; k++) begin
      @(negedge clk);
      obs[k] = uart_tx;
      if (k == 9) begin
        address      = A_DIVIDER;
        write_data   = 32'h7;
        memory_write = 1'b1;
      end else begin
        memory_write = 1'b0;
      end
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL divider_mid_frame actual=%h required=%h", obs, exp_v);
    end
    bus_read(A_DIVIDER, d);
    checks++;
    if (d !== 32'd7) begin
      errors++;
      $display("FAIL divider_readback actual=%0d required=7", d);
    end
    bus_write(A_DIVIDER, 32'h3);
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    int          waited;
    @(negedge clk);
    address      = A_TXDATA;
    memory_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_data = (i == 0) ? 32'h3C : i;
      @(negedge clk);
    end
    memory_write = 1'b0;
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 8) begin
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0501) begin
          errors++;
          $display("FAIL queued_level actual=%h required=%h", d, 32'h501);
        end
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_tx actual=%b required=1", uart_tx);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL reset_midframe_status actual=%h required=4", d);
    end
    @(negedge clk);
    reset = 1'b1;
    check_quiet("frame_after_reset");
    bus_read(A_DIVIDER, d);
    checks++;
    if (d !== 32'd216) begin
      errors++;
      $display("FAIL divider_after_reset actual=%0d required=216", d);
    end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq;
    logic [31:0] d;
    int          cyc;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_reset actual=%b required=0", irq);
    end
    bus_write(A_DIVIDER, 32'h3);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_readback actual=%h required=1", d);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_idle_empty actual=%b required=1", irq);
    end
    bus_write(A_TXDATA, 32'h5A);
    cyc = 0;
    do begin
      @(negedge clk);
      bus_read(A_STATUS, d);
      cyc++;
    end while (d[0] !== 1'b1 && cyc < 20);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_while_busy actual=%b required=0", irq);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      bus_read(A_STATUS, d);
      cyc++;
    end while (d[0] !== 1'b0 && cyc < 100);
    checks++;
    if (d !== 32'h4 || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_at_idle_entry actual status=%h irq=%b required status=4 irq=0", d, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_idle actual=%b required=1", irq);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_back_to_back();
    test_divider_change();
    test_reset_midframe();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
